servo_pwm_decoder: RTL and testbench

- Receive-side counterpart of the servo PWM generator. Measures the high time of an incoming 50 Hz servo-style pulse train on a 98.304 MHz clock.
- Quantizes each pulse to the same 0..8 angle bin code (pi/8 steps) the generator accepts.
- Used to read RC-receiver/feedback pulses and loop back generator output for self-test.
- Flags out-of-range pulses and loss of signal.

---
 rtl/servo_pwm_decoder.sv | 156 +++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// Servo pulse-width decoder: measures the high time of a 50 Hz servo pulse and quantizes it to an angle bin 0..8.
// Optional input glitch filter enabled by defining SERVO_DECODER_GLITCH_FILTER_EN.
module servo_pwm_decoder #(
    parameter int               MIN_WIDTH_CYC = 36_864,
    parameter int               MAX_WIDTH_CYC = 258_048,
    parameter int               TIMEOUT_CYC   = 3_932_160,
    parameter int               GLITCH_CYC    = 8,
    parameter logic [7:0][21:0] MID_CYC       = {22'd224_256, 22'd200_909, 22'd177_562, 22'd154_214,
                                                 22'd130_867, 22'd107_520, 22'd84_173,  22'd60_825}
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pwm_in,
    output logic [3:0]  bin_out,
    output logic [21:0] width_out,
    output logic        valid_out,
    output logic        width_err_out,
    output logic        lost_out,
    output logic [1:0]  dbg_state_out
);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2
    } state_t;

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam logic [21:0] MIN_W = 22'(MIN_WIDTH_CYC);
    localparam logic [21:0] MAX_W = 22'(MAX_WIDTH_CYC);
    localparam logic [21:0] SAT_W = 22'(MAX_WIDTH_CYC + 1);
    localparam logic [21:0] TO_W  = 22'(TIMEOUT_CYC);
    // The conditioning pipeline reads low for this many cycles after reset even if the pin is high,
    // so SYNC demands one more consecutive low than that before it trusts the level.
    localparam int SETTLE = 3 + (FILTER_EN ? GLITCH_CYC : 0);
    localparam int SW     = $clog2(SETTLE);

    state_t        state, state_nxt;
    logic          sync1, sync2, lvl, lvl_d;
    logic          rise, fall, timeout, done, in_range;
    logic [21:0]   wcnt, per_cnt;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    bin_dec;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam int FW = $clog2(GLITCH_CYC + 1);
    logic          filt;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync2 != filt) begin
            if (fcnt == FW'(GLITCH_CYC - 1)) begin
                filt <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else begin
            fcnt <= '0;
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    assign rise    = lvl & ~lvl_d;
    assign fall    = ~lvl & lvl_d;
    assign timeout = (per_cnt == TO_W);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC:      if (!lvl && settle_cnt == SW'(SETTLE - 1)) state_nxt = ST_WAIT_RISE;
            ST_WAIT_RISE: if (rise) state_nxt = ST_HIGH;
                          else if (timeout) state_nxt = ST_SYNC;
            ST_HIGH:      if (fall) state_nxt = ST_WAIT_RISE;
                          else if (timeout) state_nxt = ST_SYNC;
            default:      state_nxt = ST_SYNC;
        endcase
    end

    // bin = number of midpoints strictly below the measured width
    always_comb begin
        bin_dec = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (wcnt > MID_CYC[i]) bin_dec = bin_dec + 4'd1;
        end
    end

    assign in_range = (wcnt >= MIN_W) && (wcnt <= MAX_W);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= ST_SYNC;
            lvl_d      <= 1'b0;
            settle_cnt <= '0;
            per_cnt    <= '0;
            wcnt       <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            lvl_d <= lvl;
            done  <= (state == ST_HIGH) && fall;

            if (state != ST_SYNC || lvl) settle_cnt <= '0;
            else if (settle_cnt != SW'(SETTLE - 1)) settle_cnt <= settle_cnt + 1'b1;

            if (rise) per_cnt <= '0;
            else if (per_cnt != '1) per_cnt <= per_cnt + 22'd1;

            if (state == ST_WAIT_RISE && rise) wcnt <= 22'd1;
            else if (state == ST_HIGH && lvl && wcnt < SAT_W) wcnt <= wcnt + 22'd1;
        end
    end

    // valid_out / width_err_out are single-cycle strobes one cycle after the falling edge is registered.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bin_out       <= 4'd0;
            width_out     <= 22'd0;
            valid_out     <= 1'b0;
            width_err_out <= 1'b0;
            lost_out      <= 1'b1;
        end else begin
            valid_out     <= done && in_range;
            width_err_out <= done && !in_range;
            if (done) width_out <= wcnt;
            if (done && in_range) bin_out <= bin_dec;
            if (timeout) lost_out <= 1'b1;
            else if (done && in_range) lost_out <= 1'b0;
        end
    end

    assign dbg_state_out = state;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with time-scaled parameters (nominal bins 192 + 91*k cycles).
// Extra vectors run when SERVO_DECODER_GLITCH_FILTER_EN is defined.
module tb_servo_pwm_decoder;

    localparam int MIN_W   = 144;
    localparam int MAX_W   = 1008;
    localparam int TIMEOUT = 4000;
    localparam int PERIOD  = 2000;
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 4 + 8;
`else
    localparam int LAT = 4;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        pwm_in = 1'b0;
    logic [3:0]  bin_out;
    logic [21:0] width_out;
    logic        valid_out;
    logic        width_err_out;
    logic        lost_out;
    logic [1:0]  dbg_state_out;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    servo_pwm_decoder #(
        .MIN_WIDTH_CYC(MIN_W),
        .MAX_WIDTH_CYC(MAX_W),
        .TIMEOUT_CYC  (TIMEOUT),
        .GLITCH_CYC   (8),
        .MID_CYC      ({22'd874, 22'd783, 22'd692, 22'd601, 22'd510, 22'd419, 22'd328, 22'd237})
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pwm_in       (pwm_in),
        .bin_out      (bin_out),
        .width_out    (width_out),
        .valid_out    (valid_out),
        .width_err_out(width_err_out),
        .lost_out     (lost_out),
        .dbg_state_out(dbg_state_out)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (valid_out === 1'b1) valid_cnt++;
        if (width_err_out === 1'b1) err_cnt++;
        if (valid_out === 1'b1 && width_err_out === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 1 ns after a rising edge
    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    task automatic send_pulse(input int high, input int low);
        pwm_in = 1'b1;
        idle(high);
        pwm_in = 1'b0;
        idle(low);
    endtask

    task automatic frame(input string tag, input int high, input int exp_valid, input int exp_err,
                         input int exp_bin);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_pulse(high, PERIOD - high);
        check({tag, "_valid"}, valid_cnt - v0, exp_valid);
        check({tag, "_err"},   err_cnt - e0,   exp_err);
        check({tag, "_bin"},   bin_out,        exp_bin);
        check({tag, "_width"}, width_out,      (high > MAX_W) ? MAX_W + 1 : high);
    endtask

    initial begin
        int lost_low;
        int v0, e0;

        // reset values
        idle(3);
        @(negedge clk_in);
        check("rst_bin",   bin_out,       0);
        check("rst_width", width_out,     0);
        check("rst_valid", valid_out,     0);
        check("rst_err",   width_err_out, 0);
        check("rst_lost",  lost_out,      1);
        check("rst_state", dbg_state_out, 0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        idle(10);
        check("idle_state", dbg_state_out, 1);

        // no input at all: lost stays high, nothing decoded
        lost_low = 0;
        repeat (TIMEOUT + 500) begin
            @(negedge clk_in);
            if (!lost_out) lost_low++;
        end
        #1;
        check("idle_lost_low_cycles", lost_low, 0);
        check("idle_valid", valid_cnt, 0);

        // first frame with exact latency: valid appears LAT cycles after the pin falls
        v0 = valid_cnt;
        pwm_in = 1'b1;
        idle(192);
        pwm_in = 1'b0;
        repeat (LAT - 1) @(posedge clk_in);
        @(negedge clk_in);
        check("lat_early", valid_out, 0);
        @(negedge clk_in);
        check("lat_valid", valid_out, 1);
        check("lat_lost",  lost_out,  0);
        idle(PERIOD - 192 - LAT - 1);
        check("f192_count", valid_cnt - v0, 1);
        check("f192_bin",   bin_out,   0);
        check("f192_width", width_out, 192);

        frame("f556", 556, 1, 0, 4);
        frame("f920", 920, 1, 0, 8);
        check("lost_after_frames", lost_out, 0);

        // bin boundaries and range limits
        frame("mid237",  237,  1, 0, 0);
        frame("mid238",  238,  1, 0, 1);
        frame("short100", 100, 0, 1, 1);
        frame("min144",  144,  1, 0, 0);
        frame("min143",  143,  0, 1, 0);
        frame("max1008", 1008, 1, 0, 8);
        frame("ovf1500", 1500, 0, 1, 8);

        // reset in the middle of a pulse discards it and waits for the input to go low
        v0 = valid_cnt;
        e0 = err_cnt;
        pwm_in = 1'b1;
        idle(300);
        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        idle(100);
        check("midrst_state", dbg_state_out, 0);
        check("midrst_bin",   bin_out,  0);
        check("midrst_lost",  lost_out, 1);
        idle(338);
        pwm_in = 1'b0;
        idle(1000);
        check("midrst_valid", valid_cnt - v0, 0);
        check("midrst_err",   err_cnt - e0,   0);
        frame("f740", 740, 1, 0, 6);

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
        // 5-cycle dropout inside a pulse is absorbed; 5-cycle spike while idle is ignored
        v0 = valid_cnt;
        pwm_in = 1'b1;
        idle(200);
        pwm_in = 1'b0;
        idle(5);
        pwm_in = 1'b1;
        idle(265);
        pwm_in = 1'b0;
        idle(PERIOD - 470);
        check("glitch_drop_valid", valid_cnt - v0, 1);
        check("glitch_drop_bin",   bin_out,   3);
        check("glitch_drop_width", width_out, 470);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_pulse(5, 500);
        check("glitch_spike_valid", valid_cnt - v0, 0);
        check("glitch_spike_err",   err_cnt - e0,   0);
`endif

        // signal disappears: lost asserts after the timeout
        check("pre_timeout_lost", lost_out, 0);
        idle(TIMEOUT + 100);
        check("timeout_lost", lost_out, 1);
        check("mutual_excl",  both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
